reg_select_seq: RTL and testbench

Parametrised, registered successor to the register select-and-encode logic of the datapath. It decodes the ra/rb/rc fields of a latched instruction into one-hot register-file in/out enables and sign-extends the C constant for the bus. It also adds a built-in three-phase operand sequencer (source 1, source 2 or constant, destination), so simple three-operand instructions need no per-step Gra/Grb/Grc micro-control from the control unit. It sits between the control unit, the IR and the register file / bus mux.

---
 rtl/reg_select_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_reg_select_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_select_seq.sv
// rtl/reg_select_seq.sv - registered register select/encode with a three-phase operand sequencer; optional R0 base rule enabled by REG_SELECT_R0_ZERO_EN
module reg_select_seq #(
    parameter int NREGS  = 16,
    parameter int RW     = 4,
    parameter int DW     = 32,
    parameter int CW     = 19,
    parameter int RA_LSB = 23,
    parameter int RB_LSB = 19,
    parameter int RC_LSB = 15
) (
    input  logic             i_clock,
    input  logic             i_clear,
    input  logic [DW-1:0]    i_ir,
    input  logic             i_ir_load,
    input  logic             i_gra,
    input  logic             i_grb,
    input  logic             i_grc,
    input  logic             i_rin,
    input  logic             i_rout,
    input  logic             i_baout,
    input  logic             i_seq_start,
    input  logic             i_seq_imm,
    input  logic             i_seq_stall,
    output logic [NREGS-1:0] o_rin_vec,
    output logic [NREGS-1:0] o_rout_vec,
    output logic             o_c_out,
    output logic [DW-1:0]    o_bus_c,
    output logic             o_bus_zero,
    output logic             o_seq_busy,
    output logic             o_seq_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SRC1 = 2'd1,
        S_SRC2 = 2'd2,
        S_DST  = 2'd3
    } state_t;

    // Field index to one-hot; an index beyond the register file selects nothing.
    function automatic logic [NREGS-1:0] f_onehot(input logic [RW-1:0] idx);
        logic [NREGS-1:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) begin
            v[i] = (int'(idx) == i);
        end
        return v;
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [DW-1:0]    r_ir_q;
    logic             r_imm;
    logic             w_imm_next;

    logic [NREGS-1:0] r_rin_vec;
    logic [NREGS-1:0] r_rout_vec;
    logic             r_c_out;
    logic             r_bus_zero;
    logic             r_seq_busy;
    logic             r_seq_done;

    logic [NREGS-1:0] w_rin_vec_next;
    logic [NREGS-1:0] w_rout_vec_next;
    logic             w_c_out_next;
    logic             w_bus_zero_next;
    logic             w_seq_busy_next;
    logic             w_seq_done_next;

    logic             w_idle;
    logic [DW-1:0]    w_ir_eff;
    logic [RW-1:0]    w_ra;
    logic [RW-1:0]    w_rb;
    logic [RW-1:0]    w_rc;
    logic             w_sel_any;
    logic [RW-1:0]    w_sel_idx;
    logic             w_out_en;
    logic [NREGS-1:0] w_man_rin;
    logic [NREGS-1:0] w_man_rout;
    logic             w_man_bus_zero;
    logic             w_unused_ir;

    // The instruction register only accepts a new word while idle, so a load
    // coincident with seq_start is the word that gets sequenced.
    assign w_idle   = (r_state == S_IDLE);
    assign w_ir_eff = (w_idle && i_ir_load) ? i_ir : r_ir_q;

    assign w_ra = w_ir_eff[RA_LSB +: RW];
    assign w_rb = w_ir_eff[RB_LSB +: RW];
    assign w_rc = w_ir_eff[RC_LSB +: RW];

    // Bits of the IR outside the decoded fields are intentionally unused here.
    assign w_unused_ir = ^r_ir_q;

    // Manual field select with priority a > b > c.
    assign w_sel_any = i_gra | i_grb | i_grc;
    assign w_sel_idx = i_gra ? w_ra : (i_grb ? w_rb : w_rc);
    assign w_out_en  = i_rout | i_baout;

    // Constant is always available on the bus side, sign-extended from its top bit.
    assign o_bus_c = {{(DW-CW){r_ir_q[CW-1]}}, r_ir_q[CW-1:0]};

    // Manual decode of the selected field into in/out enables.
    always_comb begin
        w_man_rin      = '0;
        w_man_rout     = '0;
        w_man_bus_zero = 1'b0;
        if (w_sel_any) begin
            if (i_rin) begin
                w_man_rin = f_onehot(w_sel_idx);
            end
            if (w_out_en) begin
                w_man_rout = f_onehot(w_sel_idx);
            end
`ifdef REG_SELECT_R0_ZERO_EN
            // Base-address reads of R0 mean "zero": suppress R0 and drive zero instead.
            // An explicit rout still reads R0 as a normal register.
            if (i_baout && !i_rout && (w_sel_idx == '0)) begin
                w_man_rout[0]  = 1'b0;
                w_man_bus_zero = 1'b1;
            end
`endif
        end
    end

    // Next state and next registered outputs; a stall simply keeps everything.
    always_comb begin
        w_state_next    = r_state;
        w_imm_next      = r_imm;
        w_rin_vec_next  = r_rin_vec;
        w_rout_vec_next = r_rout_vec;
        w_c_out_next    = r_c_out;
        w_bus_zero_next = r_bus_zero;
        w_seq_done_next = r_seq_done;
        case (r_state)
            S_IDLE: begin
                w_c_out_next    = 1'b0;
                w_seq_done_next = 1'b0;
                if (i_seq_start) begin
                    w_state_next    = S_SRC1;
                    w_imm_next      = i_seq_imm;
                    w_rin_vec_next  = '0;
                    w_rout_vec_next = f_onehot(w_rb);
                    w_bus_zero_next = 1'b0;
                end else begin
                    w_rin_vec_next  = w_man_rin;
                    w_rout_vec_next = w_man_rout;
                    w_bus_zero_next = w_man_bus_zero;
                end
            end
            S_SRC1: begin
                if (!i_seq_stall) begin
                    w_state_next    = S_SRC2;
                    w_rin_vec_next  = '0;
                    w_rout_vec_next = r_imm ? '0 : f_onehot(w_rc);
                    w_c_out_next    = r_imm;
                    w_bus_zero_next = 1'b0;
                    w_seq_done_next = 1'b0;
                end
            end
            S_SRC2: begin
                if (!i_seq_stall) begin
                    w_state_next    = S_DST;
                    w_rin_vec_next  = f_onehot(w_ra);
                    w_rout_vec_next = '0;
                    w_c_out_next    = 1'b0;
                    w_bus_zero_next = 1'b0;
                    w_seq_done_next = 1'b1;
                end
            end
            S_DST: begin
                // Leaving DST samples everything while still busy, so manual
                // inputs and seq_start on this edge are ignored.
                if (!i_seq_stall) begin
                    w_state_next    = S_IDLE;
                    w_rin_vec_next  = '0;
                    w_rout_vec_next = '0;
                    w_c_out_next    = 1'b0;
                    w_bus_zero_next = 1'b0;
                    w_seq_done_next = 1'b0;
                end
            end
            default: begin
                w_state_next    = S_IDLE;
                w_rin_vec_next  = '0;
                w_rout_vec_next = '0;
                w_c_out_next    = 1'b0;
                w_bus_zero_next = 1'b0;
                w_seq_done_next = 1'b0;
            end
        endcase
        w_seq_busy_next = (w_state_next != S_IDLE);
    end

    // State, latched instruction and registered outputs.
    always_ff @(posedge i_clock or negedge i_clear) begin
        if (!i_clear) begin
            r_state    <= S_IDLE;
            r_ir_q     <= '0;
            r_imm      <= 1'b0;
            r_rin_vec  <= '0;
            r_rout_vec <= '0;
            r_c_out    <= 1'b0;
            r_bus_zero <= 1'b0;
            r_seq_busy <= 1'b0;
            r_seq_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ir_q     <= w_ir_eff;
            r_imm      <= w_imm_next;
            r_rin_vec  <= w_rin_vec_next;
            r_rout_vec <= w_rout_vec_next;
            r_c_out    <= w_c_out_next;
            r_bus_zero <= w_bus_zero_next;
            r_seq_busy <= w_seq_busy_next;
            r_seq_done <= w_seq_done_next;
        end
    end

    assign o_rin_vec  = r_rin_vec;
    assign o_rout_vec = r_rout_vec;
    assign o_c_out    = r_c_out;
    assign o_bus_zero = r_bus_zero;
    assign o_seq_busy = r_seq_busy;
    assign o_seq_done = r_seq_done;

endmodule

// File: tb/tb_reg_select_seq.sv
// tb/tb_reg_select_seq.sv - randomized self-checking bench for reg_select_seq with a phase-level reference model
module tb_reg_select_seq;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] ir = '0;
    logic        ir_load = 1'b0;
    logic        gra = 1'b0, grb = 1'b0, grc = 1'b0;
    logic        rin = 1'b0, rout = 1'b0, baout = 1'b0;
    logic        seq_start = 1'b0, seq_imm = 1'b0, seq_stall = 1'b0;
    logic [15:0] rin_vec, rout_vec;
    logic        c_out, bus_zero, seq_busy, seq_done;
    logic [31:0] bus_c;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    reg_select_seq dut (
        .i_clock     (clk),
        .i_clear     (clear),
        .i_ir        (ir),
        .i_ir_load   (ir_load),
        .i_gra       (gra),
        .i_grb       (grb),
        .i_grc       (grc),
        .i_rin       (rin),
        .i_rout      (rout),
        .i_baout     (baout),
        .i_seq_start (seq_start),
        .i_seq_imm   (seq_imm),
        .i_seq_stall (seq_stall),
        .o_rin_vec   (rin_vec),
        .o_rout_vec  (rout_vec),
        .o_c_out     (c_out),
        .o_bus_c     (bus_c),
        .o_bus_zero  (bus_zero),
        .o_seq_busy  (seq_busy),
        .o_seq_done  (seq_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase 0 = idle, 1 = first source, 2 = second source/constant, 3 = destination.
    int          m_ph = 0;
    logic [31:0] m_ir = '0;
    bit          m_imm = 1'b0;
    logic [15:0] e_rin = '0, e_rout = '0;
    logic        e_c = 1'b0, e_bz = 1'b0, e_busy = 1'b0, e_done = 1'b0;

    function automatic int fld(input logic [31:0] w, input int lsb);
        return int'((w >> lsb) & 32'hF);
    endfunction

    function automatic logic [15:0] oh(input int idx);
        logic [31:0] t;
        t = 32'd1 << idx;
        return (idx < 16) ? t[15:0] : 16'h0;
    endfunction

    always @(posedge clk or negedge clear) begin
        if (!clear) begin
            m_ph = 0; m_ir = '0; m_imm = 1'b0;
            e_rin = '0; e_rout = '0; e_c = 1'b0; e_bz = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            logic [15:0] man_rin, man_rout;
            logic        man_bz;
            int          sel;
            man_rin = '0; man_rout = '0; man_bz = 1'b0;
            if (m_ph == 0) begin
                if (ir_load) m_ir = ir;
                if (seq_start) begin
                    m_ph  = 1;
                    m_imm = seq_imm;
                end else if (gra || grb || grc) begin
                    sel = gra ? fld(m_ir, 23) : (grb ? fld(m_ir, 19) : fld(m_ir, 15));
                    if (rin) man_rin = oh(sel);
                    if (rout || baout) man_rout = oh(sel);
`ifdef REG_SELECT_R0_ZERO_EN
                    if (baout && !rout && sel == 0) begin
                        man_rout = '0;
                        man_bz   = 1'b1;
                    end
`endif
                end
            end else if (!seq_stall) begin
                m_ph = (m_ph + 1) % 4;
            end
            e_busy = (m_ph != 0);
            e_done = (m_ph == 3);
            e_c    = (m_ph == 2) && m_imm;
            e_bz   = (m_ph == 0) ? man_bz : 1'b0;
            case (m_ph)
                0: begin e_rin = man_rin;          e_rout = man_rout; end
                1: begin e_rin = '0;               e_rout = oh(fld(m_ir, 19)); end
                2: begin e_rin = '0;               e_rout = m_imm ? 16'h0 : oh(fld(m_ir, 15)); end
                default: begin e_rin = oh(fld(m_ir, 23)); e_rout = '0; end
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [31:0] exp_c;
            exp_c = 32'($signed(m_ir[18:0]));
            chk("rin_vec",  32'(rin_vec),  32'(e_rin));
            chk("rout_vec", 32'(rout_vec), 32'(e_rout));
            chk("c_out",    32'(c_out),    32'(e_c));
            chk("bus_zero", 32'(bus_zero), 32'(e_bz));
            chk("seq_busy", 32'(seq_busy), 32'(e_busy));
            chk("seq_done", 32'(seq_done), 32'(e_done));
            chk("bus_c",    bus_c,         exp_c);
            chk("rin_onehot",  32'($countones(rin_vec) <= 1),  32'd1);
            chk("rout_onehot", 32'($countones(rout_vec) <= 1), 32'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ir_load = 0; gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; baout = 0;
        seq_start = 0; seq_imm = 0; seq_stall = 0;
    endtask

    initial begin
        idle_in();
        clear = 1'b0;
        repeat (3) cyc();
        chk("reset_rin",  32'(rin_vec),  32'h0);
        chk("reset_rout", 32'(rout_vec), 32'h0);
        chk("reset_busy", 32'(seq_busy), 32'h0);
        chk("reset_busc", bus_c,         32'h0);
        cmp_en = 1'b1;
        clear  = 1'b1;

        // Manual decode
        ir = 32'h01AB8000; ir_load = 1; cyc(); ir_load = 0;
        chk("dec_bus_c", bus_c, 32'h00038000);
        gra = 1; rin = 1; cyc();
        chk("man_gra_rin", 32'(rin_vec), 32'h0008);
        gra = 0; rin = 0; grb = 1; rout = 1; cyc();
        chk("man_grb_rout", 32'(rout_vec), 32'h0020);
        chk("man_grb_rin0", 32'(rin_vec), 32'h0000);
        grb = 0; grc = 1; gra = 1; cyc();
        chk("man_prio", 32'(rout_vec), 32'h0008);
        idle_in(); cyc();
        chk("man_none", 32'(rout_vec), 32'h0000);

        // Sign extension
        ir = 32'h00040000; ir_load = 1; cyc();
        chk("sext_neg", bus_c, 32'hFFFC0000);
        ir = 32'h0003FFFF; cyc();
        chk("sext_pos", bus_c, 32'h0003FFFF);
        ir_load = 0;

        // Sequence with coincident load, register second source
        ir = 32'h01AB8000; ir_load = 1; seq_start = 1; seq_imm = 0; cyc();
        ir_load = 0; seq_start = 0;
        chk("seq_src1", 32'(rout_vec), 32'h0020);
        chk("seq_busy1", 32'(seq_busy), 32'h1);
        cyc();
        chk("seq_src2", 32'(rout_vec), 32'h0080);
        cyc();
        chk("seq_dst", 32'(rin_vec), 32'h0008);
        chk("seq_done", 32'(seq_done), 32'h1);
        cyc();
        chk("seq_end_busy", 32'(seq_busy), 32'h0);
        chk("seq_end_done", 32'(seq_done), 32'h0);

        // Immediate second source
        seq_start = 1; seq_imm = 1; cyc(); seq_start = 0; seq_imm = 0; cyc();
        chk("imm_c_out", 32'(c_out), 32'h1);
        chk("imm_rout0", 32'(rout_vec), 32'h0);
        cyc(); cyc();

        // Stall in SRC2 and ignored inputs while busy
        seq_start = 1; cyc(); seq_start = 0;
        ir = 32'hFFFFFFFF; ir_load = 1; gra = 1; rin = 1; cyc();
        chk("stall_src2", 32'(rout_vec), 32'h0080);
        seq_stall = 1; cyc();
        chk("stall_hold1", 32'(rout_vec), 32'h0080);
        cyc();
        chk("stall_hold2", 32'(rout_vec), 32'h0080);
        chk("busy_ignore_ir", bus_c, 32'h00038000);
        seq_stall = 0; cyc();
        chk("stall_dst", 32'(rin_vec), 32'h0008);
        cyc();
        chk("exit_ignore_rin", 32'(rin_vec), 32'h0000);
        chk("exit_ignore_ir", bus_c, 32'h00038000);
        idle_in(); cyc();

        // Back-to-back: held seq_start is ignored on the edge leaving DST
        seq_start = 1; cyc(); cyc(); cyc(); cyc();
        chk("b2b_ignored", 32'(seq_busy), 32'h0);
        cyc();
        chk("b2b_restart", 32'(seq_busy), 32'h1);
        seq_start = 0; cyc(); cyc(); cyc();

        // Asynchronous reset during SRC2
        ir = 32'h01AB8000; ir_load = 1; seq_start = 1; cyc(); idle_in(); cyc();
        #2 clear = 1'b0;
        #1;
        chk("rst_rout", 32'(rout_vec), 32'h0);
        chk("rst_busy", 32'(seq_busy), 32'h0);
        chk("rst_busc", bus_c, 32'h0);
        cyc();
        clear = 1'b1;
        ir = 32'h01AB8000; ir_load = 1; seq_start = 1; cyc(); idle_in();
        chk("rst_src1", 32'(rout_vec), 32'h0020);
        cyc(); cyc();
        chk("rst_dst", 32'(rin_vec), 32'h0008);
        cyc();

        // R0 base rule
        ir = 32'h00280000; ir_load = 1; cyc(); ir_load = 0;
        gra = 1; baout = 1; cyc();
`ifdef REG_SELECT_R0_ZERO_EN
        chk("r0_ba_rout", 32'(rout_vec), 32'h0000);
        chk("r0_ba_bz",   32'(bus_zero), 32'h1);
`else
        chk("r0_ba_rout", 32'(rout_vec), 32'h0001);
        chk("r0_ba_bz",   32'(bus_zero), 32'h0);
`endif
        baout = 0; rout = 1; cyc();
        chk("r0_rout", 32'(rout_vec), 32'h0001);
        chk("r0_rout_bz", 32'(bus_zero), 32'h0);
        idle_in(); cyc();

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            ir        = $urandom();
            ir_load   = ($urandom_range(0, 4) == 0);
            gra       = $urandom_range(0, 1);
            grb       = $urandom_range(0, 1);
            grc       = $urandom_range(0, 1);
            rin       = $urandom_range(0, 1);
            rout      = $urandom_range(0, 1);
            baout     = $urandom_range(0, 1);
            seq_start = ($urandom_range(0, 2) == 0);
            seq_imm   = $urandom_range(0, 1);
            seq_stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 clear = 1'b0;
                cyc();
                clear = 1'b1;
            end else begin
                cyc();
            end
        end
        idle_in();
        repeat (4) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
